mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory between the CPU control unit/datapath (requester 0) and the program-loader/DMA port (requester 1).
- The CPU asserts a lock across its multi-cycle instruction: opcode fetch, then address MSB/LSB fetch, then STAC/LDAC or jump. This keeps the loader from interleaving mid-instruction.
- The CPU is stalled via cpu_stall whenever its request is not granted.
- Memory is combinational-read and synchronous-write; the arbiter only muxes address, write data and write enable.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU/loader memory port arbiter.
// owner_t tracks who holds the single memory port; req_t records the last owner to exit.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU (lockable across an
// instruction) and the program-loader/DMA port (burst-limited while the CPU waits).
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_lock,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    owner_t     owner_q, owner_d;
    req_t       last_q, last_d;
    logic [3:0] burst_q, burst_d;
    logic [3:0] burst_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            last_q  <= REQ_DMA;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        burst_d   = burst_q;
        cpu_gnt   = (owner_q == OWN_CPU) && cpu_req;
        dma_gnt   = (owner_q == OWN_DMA) && dma_req;
        cpu_stall = cpu_req && !cpu_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;

        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end

        // Count includes the beat in flight, so a waiting CPU takes over right after beat MAX_BURST.
        if (dma_gnt && (burst_q != BURST_MAX))
            burst_n = burst_q + 4'd1;
        else
            burst_n = burst_q;

        unique case (owner_q)
            OWN_NONE: begin
                if (cpu_req && dma_req)
                    owner_d = (last_q == REQ_DMA) ? OWN_CPU : OWN_DMA;
                else if (cpu_req)
                    owner_d = OWN_CPU;
                else if (dma_req)
                    owner_d = OWN_DMA;
            end
            OWN_CPU: begin
                if (!cpu_req && !cpu_lock) begin
                    owner_d = dma_req ? OWN_DMA : OWN_NONE;
                    last_d  = REQ_CPU;
                end
            end
            OWN_DMA: begin
                burst_d = burst_n;
                if ((cpu_req && (burst_n == BURST_MAX)) || !dma_req) begin
                    owner_d = cpu_req ? OWN_CPU : OWN_NONE;
                    last_d  = REQ_DMA;
                end
            end
            default: owner_d = OWN_NONE;
        endcase

        if ((owner_d == OWN_DMA) && (owner_q != OWN_DMA))
            burst_d = '0;
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a tenure-level ownership model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_lock = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt, cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_gnt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [7:0]  rdata;

    logic [7:0]  mem [0:65535];

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write at posedge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Ownership model: 0 = nobody, 1 = CPU, 2 = loader.
    int m_owner = 0;
    int m_beats = 0;
    bit m_cpu_exited_last = 1'b0;

    always @(posedge reset) begin
        m_owner = 0;
        m_beats = 0;
        m_cpu_exited_last = 1'b0;
    end

    always @(negedge clk) begin : compare
        logic        e_cg, e_dg, e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        int          nb;
        if (reset) begin
            m_owner = 0;
            m_beats = 0;
            m_cpu_exited_last = 1'b0;
        end
        e_cg = (m_owner == 1) && cpu_req;
        e_dg = (m_owner == 2) && dma_req;
        e_addr = e_cg ? cpu_addr  : (e_dg ? dma_addr  : 16'h0000);
        e_wd   = e_cg ? cpu_wdata : (e_dg ? dma_wdata : 8'h00);
        e_we   = e_cg ? cpu_we    : (e_dg ? dma_we    : 1'b0);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("dma_gnt", 32'(dma_gnt), 32'(e_dg));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cg));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("we_needs_gnt", 32'(mem_we && !(cpu_gnt || dma_gnt)), 32'd0);
        chk("rdata", 32'(rdata), 32'(mem[e_addr]));
        if (!reset) begin
            if (m_owner == 0) begin
                if (cpu_req && dma_req) m_owner = m_cpu_exited_last ? 2 : 1;
                else if (cpu_req)       m_owner = 1;
                else if (dma_req)       m_owner = 2;
                if (m_owner == 2) m_beats = 0;
            end else if (m_owner == 1) begin
                if (!cpu_req && !cpu_lock) begin
                    m_cpu_exited_last = 1'b1;
                    m_owner = dma_req ? 2 : 0;
                    m_beats = 0;
                end
            end else begin
                nb = m_beats + (e_dg ? 1 : 0);
                if (nb > MAXB) nb = MAXB;
                m_beats = nb;
                if ((cpu_req && nb >= MAXB) || !dma_req) begin
                    m_cpu_exited_last = 1'b0;
                    m_owner = cpu_req ? 1 : 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbeats, last_beat, cpu_at, idx;
        logic g;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h00FF] = 8'h5A;

        // Reset values, with cpu_req already high.
        cpu_req = 1'b1;
        step();
        @(negedge clk);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t1_c1_stall", 32'(cpu_stall), 32'd1);
        step();
        @(negedge clk);
        chk("t1_c2_gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_c2_stall", 32'(cpu_stall), 32'd0);
        chk("t1_c2_addr", 32'(mem_addr), 32'h0000);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        step();

        // Locked CPU instruction holds off a waiting loader.
        cpu_req = 1'b1; cpu_lock = 1'b1; cpu_addr = 16'h0010;
        @(negedge clk);
        step();
        dma_req = 1'b1; dma_addr = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            cpu_req = (i % 2 == 0);
            cpu_addr = 16'h0010 + 16'(i);
            @(negedge clk);
            chk("lock_dma_gnt", 32'(dma_gnt), 32'd0);
            chk("lock_cpu_gnt", 32'(cpu_gnt), 32'(i % 2 == 0));
            step();
        end
        cpu_req = 1'b0; cpu_lock = 1'b0;
        @(negedge clk);
        chk("unlock_dma_gnt0", 32'(dma_gnt), 32'd0);
        step();
        @(negedge clk);
        chk("unlock_dma_gnt1", 32'(dma_gnt), 32'd1);
        chk("unlock_addr", 32'(mem_addr), 32'h0200);
        step();
        dma_req = 1'b0;
        @(negedge clk);
        step();

        // Loader burst interrupted by a waiting CPU.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0100; dma_wdata = 8'h11;
        cpu_addr = 16'h0040; cpu_we = 1'b0;
        nbeats = 0; last_beat = -1; cpu_at = -1; idx = 0;
        for (int c = 0; c < 20 && cpu_at < 0; c++) begin
            @(negedge clk);
            g = dma_gnt;
            if (g) begin nbeats++; last_beat = c; end
            if (cpu_gnt) cpu_at = c;
            step();
            if (g && idx < 5) begin
                idx++;
                dma_addr = 16'h0100 + 16'(idx);
                dma_wdata = 8'h11 + 8'(idx);
                cpu_req = 1'b1;
            end
        end
        chk("burst_beats", 32'(nbeats), 32'd4);
        chk("burst_cpu_seen", 32'(cpu_at >= 0), 32'd1);
        chk("burst_handover", 32'(cpu_at - last_beat), 32'd1);
        chk("mem_0100", 32'(mem[16'h0100]), 32'h11);
        chk("mem_0101", 32'(mem[16'h0101]), 32'h12);
        chk("mem_0102", 32'(mem[16'h0102]), 32'h13);
        chk("mem_0103", 32'(mem[16'h0103]), 32'h14);
        chk("mem_0104", 32'(mem[16'h0104]), 32'h00);
        cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        @(negedge clk);
        step();

        // Tie-break from idle.
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 16'h0020; dma_addr = 16'h0300;
        @(negedge clk);
        chk("tie0_none", 32'({cpu_gnt, dma_gnt}), 32'd0);
        step();
        @(negedge clk);
        chk("tie0_winner", 32'({cpu_gnt, dma_gnt}), 32'b10);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("tie0_dma_follow", 32'(dma_gnt), 32'd1);
        step();
        dma_req = 1'b0;
        @(negedge clk);
        step();
        cpu_req = 1'b1; dma_req = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("tie_after_dma", 32'({cpu_gnt, dma_gnt}), 32'b10);
        step();
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        step();
        cpu_req = 1'b1; dma_req = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("tie_after_cpu", 32'({cpu_gnt, dma_gnt}), 32'b01);
        chk("tie_after_cpu_stall", 32'(cpu_stall), 32'd1);
        step();
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        step();

        // Reset arriving during a granted CPU write.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00FF;
        @(negedge clk);
        step();
        cpu_we = 1'b1; cpu_wdata = 8'hA5;
        @(negedge clk);
        chk("stac_we_pre", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("stac_we_rst", 32'(mem_we), 32'd0);
        chk("stac_gnt_rst", 32'(cpu_gnt), 32'd0);
        chk("stac_stall_rst", 32'(cpu_stall), 32'd1);
        step();
        chk("stac_mem_kept", 32'(mem[16'h00FF]), 32'h5A);
        cpu_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("stac_owner_none", 32'(cpu_stall), 32'd1);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        step();

        // Write enables asserted with no request never reach memory.
        cpu_we = 1'b1; dma_we = 1'b1; cpu_addr = 16'h1234; dma_addr = 16'h4321;
        cpu_wdata = 8'hEE; dma_wdata = 8'hDD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nogrant_we", 32'(mem_we), 32'd0);
            chk("nogrant_addr", 32'(mem_addr), 32'd0);
            step();
        end
        chk("nogrant_mem", 32'(mem[16'h1234]), 32'h00);
        cpu_we = 1'b0; dma_we = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
